// File: rtl/mips_mult_pkg.sv
// mips_mult_pkg: shared state encoding and default sizes for the MULT/MULTU sequencer
package mips_mult_pkg;
  localparam int WIDTH_D = 32;
  localparam int CNT_W_D = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;
endpackage

// File: rtl/mips_mult_shift_add.sv
// mips_mult_shift_add: sign-magnitude shift-add multiplier datapath with HI/LO result registers
module mips_mult_shift_add #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             finish,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [WIDTH-1:0] mcand, mplier, acc_hi, mag_a, mag_b;
  logic [WIDTH:0] sum;
  logic [2*WIDTH-1:0] acc;
  logic neg;
  // the most negative operand negates to itself, which is its correct unsigned magnitude
  assign mag_a = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign mag_b = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  assign sum = mplier[0] ? {1'b0, acc_hi} + {1'b0, mcand} : {1'b0, acc_hi};
  assign acc = {acc_hi, mplier};
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand <= '0;
      mplier <= '0;
      acc_hi <= '0;
      neg <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      if (load) begin
        mcand <= mag_a;
        mplier <= mag_b;
        acc_hi <= '0;
        neg <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      end else if (step) begin
        acc_hi <= sum[WIDTH:1];
        mplier <= {sum[0], mplier[WIDTH-1:1]};
      end
      if (finish) {hi, lo} <= neg ? -acc : acc;
    end
  end
endmodule

// File: rtl/mips_mult_sequencer.sv
// mips_mult_sequencer: multi-cycle MULT/MULTU control FSM with PC stall gating
module mips_mult_sequencer
  import mips_mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             pc_en_in,
  output logic             pc_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic load, step, finish;
  assign load = (state == IDLE) && start;
  assign step = state == RUN;
  assign finish = state == FIN;
  assign busy = state != IDLE;
  assign pc_en = pc_en_in & ~load & ~step;
  always_comb begin
    state_n = IDLE;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (state == RUN) state_n = (cnt == CNT_W'(WIDTH - 1)) ? FIN : RUN;
  end
  // done is registered alongside hi/lo so it marks the first cycle the result is visible
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      done <= finish;
      cnt <= load ? '0 : step ? cnt + 1'b1 : cnt;
    end
  end
  mips_mult_shift_add #(.WIDTH(WIDTH)) u_dp (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(step),
    .finish(finish),
    .is_signed(is_signed),
    .op_a(op_a),
    .op_b(op_b),
    .hi(hi),
    .lo(lo)
  );
endmodule

// File: tb/tb_mips_mult_sequencer.sv
// tb_mips_mult_sequencer: randomized self-checking bench against a 64-bit arithmetic product model
module tb_mips_mult_sequencer;
  logic clk = 0, rst = 1, start = 0, is_signed = 0, pc_en_in = 1;
  logic [31:0] op_a = '0, op_b = '0;
  logic pc_en, busy, done;
  logic [31:0] hi, lo;
  logic [63:0] last = '0;
  int vectors = 0, miscompares = 0;
  mips_mult_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .pc_en_in(pc_en_in), .pc_en(pc_en), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_prod(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = sg ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return sa * sb;
  endfunction
  task automatic quiet(input int n, input string tag);
    int pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk(tag, pulses, 0);
  endtask
  // mode 0: plain op, 1: extra start at RUN cycle 10, 2: reset at RUN cycle 15
  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input logic pen, input int mode);
    int k, pl;
    logic [63:0] exp;
    exp = ref_prod(sg, a, b);
    @(posedge clk); #1;
    start = 1; is_signed = sg; op_a = a; op_b = b; pc_en_in = pen;
    pl = 0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!pc_en) pl++;
      if (done) break;
      if (k == 5) begin
        chk("busy_run", busy, 1);
        chk("hold_hilo", {hi, lo}, last);
      end
      @(posedge clk); #1;
      start = 0;
      op_a = $urandom; op_b = $urandom; is_signed = $urandom_range(0, 1);
      if (mode == 1 && k == 9) start = 1;
      if (mode == 2 && k == 14) begin
        rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hilo", {hi, lo}, 0);
        last = '0;
        quiet(40, "rst_no_done");
        return;
      end
    end
    chk("latency", k, 34);
    chk("hilo", {hi, lo}, exp);
    chk("pc_low", pl, pen ? 33 : 35);
    last = exp;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    if (mode == 1) quiet(40, "no_restart");
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic [31:0] edges [4] = '{32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hilo", {hi, lo}, 0);
    chk("reset_pc_en", pc_en, 1);
    run_op(0, 7, 6, 1, 0);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    run_op(1, 32'hFFFF_FFFD, 5, 1, 0);
    run_op(0, 32'hFFFF_FFFD, 5, 1, 0);
    run_op(1, 32'h8000_0000, 32'h8000_0000, 1, 0);
    run_op(1, 0, 32'h1234, 1, 0);
    run_op(0, 32'h0001_0003, 32'h0200_0011, 1, 1);
    run_op(1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 2);
    run_op(1, 32'hFFFF_FFF9, 32'h0000_0013, 1, 0);
    for (int i = 0; i < 12; i++) begin
      ra = (i % 3 == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      rb = (i % 4 == 1) ? edges[$urandom_range(0, 3)] : $urandom;
      run_op($urandom_range(0, 1), ra, rb, $urandom_range(0, 3) != 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
